// File: rtl/zed_io_pkg.sv
// Shared types and board defaults for the ZedBoard I/O blocks.
// Holds the per-button state encoding and a small constant helper.
package zed_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_e;

    localparam int ZED_GCLK_HZ = 100_000_000;
    localparam int ZED_NUM_BTN = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/zed_btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, press/release FSM.
// Auto-repeat timing is built only when ZED_BTN_AUTOREPEAT_EN is defined.
module zed_btn_debounce_ch
    import zed_io_pkg::*;
#(
    parameter int DB_CYCLES         = 1_000_000,
    parameter int RPT_DELAY_CYCLES  = 50_000_000,
    parameter int RPT_PERIOD_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int               CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_reg;
    logic             s_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             press_reg;
    logic             release_reg;
    btn_state_e       state_reg;
    logic             accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            s_reg     <= 1'b0;
        end else begin
            sync1_reg <= btn_raw;
            s_reg     <= sync1_reg;
        end
    end

    // Any sample that agrees with the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            level_reg <= 1'b0;
        end else if (s_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            level_reg <= ~level_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign accept = (s_reg != level_reg) && (cnt_reg == CNT_LAST);

`ifdef ZED_BTN_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(max_int(RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES) + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(RPT_DELAY_CYCLES - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(RPT_PERIOD_CYCLES - 1);

    logic [RPT_W-1:0] rpt_cnt_reg;
    logic             repeat_reg;
    logic             rpt_due;

    assign rpt_due    = (rpt_cnt_reg == ((state_reg == REPEAT) ? PERIOD_LAST : DELAY_LAST));
    assign btn_repeat = repeat_reg;
`else
    assign btn_repeat = 1'b0;
`endif

    // Release is checked first so a repeat can never share the release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
`ifdef ZED_BTN_AUTOREPEAT_EN
            rpt_cnt_reg <= '0;
            repeat_reg  <= 1'b0;
`endif
        end else begin
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
`ifdef ZED_BTN_AUTOREPEAT_EN
            repeat_reg  <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        press_reg <= 1'b1;
                        state_reg <= HELD;
`ifdef ZED_BTN_AUTOREPEAT_EN
                        rpt_cnt_reg <= '0;
`endif
                    end
                end
                HELD, REPEAT: begin
                    if (accept) begin
                        release_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
`ifdef ZED_BTN_AUTOREPEAT_EN
                    else if (rpt_due) begin
                        press_reg   <= 1'b1;
                        repeat_reg  <= 1'b1;
                        rpt_cnt_reg <= '0;
                        state_reg   <= REPEAT;
                    end else begin
                        rpt_cnt_reg <= rpt_cnt_reg + 1'b1;
                    end
`endif
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

endmodule

// File: rtl/zed_btn_input.sv
// ZedBoard push-button conditioner: NUM_BTN independent debounced channels.
// Define ZED_BTN_AUTOREPEAT_EN to enable hold-to-repeat press pulses.
module zed_btn_input
    import zed_io_pkg::*;
#(
    parameter int NUM_BTN           = ZED_NUM_BTN,
    parameter int DB_CYCLES         = ZED_GCLK_HZ / 100,
    parameter int RPT_DELAY_CYCLES  = 50_000_000,
    parameter int RPT_PERIOD_CYCLES = 10_000_000
) (
    input  logic               GCLK,
    input  logic               RSTN,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_repeat
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            zed_btn_debounce_ch #(
                .DB_CYCLES         (DB_CYCLES),
                .RPT_DELAY_CYCLES  (RPT_DELAY_CYCLES),
                .RPT_PERIOD_CYCLES (RPT_PERIOD_CYCLES)
            ) u_ch (
                .clk         (GCLK),
                .rst_n       (RSTN),
                .btn_raw     (BTN[gi]),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi]),
                .btn_repeat  (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_zed_btn_input.sv
// Self-checking bench for zed_btn_input: directed scenarios plus random button noise
// compared every cycle against a sample-history reference model.
module tb_zed_btn_input;

    localparam int NB = 5;
    localparam int DB = 8;
    localparam int RD = 40;
    localparam int RP = 10;

    logic          gclk = 1'b0;
    logic          rstn = 1'b0;
    logic [NB-1:0] btn  = '0;
    logic [NB-1:0] level, press, rel, rpt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: raw sample history (bit 0 = newest edge sample).
    logic [31:0]   hbits [NB];
    logic [NB-1:0] m_level, e_press, e_rel, e_rpt;
    int            held  [NB];

    zed_btn_input #(
        .NUM_BTN           (NB),
        .DB_CYCLES         (DB),
        .RPT_DELAY_CYCLES  (RD),
        .RPT_PERIOD_CYCLES (RP)
    ) dut (
        .GCLK        (gclk),
        .RSTN        (rstn),
        .BTN         (btn),
        .btn_level   (level),
        .btn_press   (press),
        .btn_release (rel),
        .btn_repeat  (rpt)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            hbits[i] = '0;
            held[i]  = 0;
        end
        m_level = '0;
        e_press = '0;
        e_rel   = '0;
        e_rpt   = '0;
    endtask

    // Level flips once the DB samples seen through the 2-cycle synchronizer
    // all disagree with the current level; repeats follow hold time arithmetic.
    task automatic model_edge(input logic [NB-1:0] smp);
        logic [DB-1:0] win;
        for (int i = 0; i < NB; i++) begin
            hbits[i]   = {hbits[i][30:0], smp[i]};
            e_press[i] = 1'b0;
            e_rel[i]   = 1'b0;
            e_rpt[i]   = 1'b0;
            win = hbits[i][DB+1:2];
            if (m_level[i] ? (win == '0) : (&win)) begin
                if (!m_level[i]) begin
                    m_level[i] = 1'b1;
                    e_press[i] = 1'b1;
                    held[i]    = 0;
                end else begin
                    m_level[i] = 1'b0;
                    e_rel[i]   = 1'b1;
                end
            end else if (m_level[i]) begin
                held[i]++;
`ifdef ZED_BTN_AUTOREPEAT_EN
                if (held[i] >= RD && ((held[i] - RD) % RP) == 0) begin
                    e_press[i] = 1'b1;
                    e_rpt[i]   = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic step();
        logic [NB-1:0] smp;
        smp = btn;
        @(posedge gclk);
        cyc++;
        #1;
        if (!rstn) model_reset();
        else       model_edge(smp);
        chk("level",   32'(level), 32'(m_level));
        chk("press",   32'(press), 32'(e_press));
        chk("release", 32'(rel),   32'(e_rel));
        chk("repeat",  32'(rpt),   32'(e_rpt));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic assert_reset();
        rstn = 1'b0;
        #1;
        chk("async_rst_out", 32'({level, press, rel, rpt}), 32'd0);
    endtask

    initial begin
        int lat;
        int cnt_a;
        int cnt_b;
        int exp_rpts;
        int noisy;
        model_reset();

        // Buttons held through reset: quiet during reset, one press per channel after.
        btn = '1;
        steps(3);
        rstn = 1'b1;
        lat  = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (press === 5'h1F && lat < 0) lat = k;
        end
        $display("reset release: press latency %0d", lat);
        chk("rst_press_lat", 32'(lat >= DB + 1 && lat <= DB + 3), 32'd1);
        btn = '0;
        steps(15);

        // Bouncing press on channel 0.
        cnt_a = 0; cnt_b = 0; lat = -1;
        for (int k = 0; k < 10; k++) begin
            btn[0] = (k % 2 == 0);
            for (int j = 0; j < 3; j++) begin
                step();
                cnt_a += int'(press[0]);
                cnt_b += int'(rel[0]);
            end
        end
        btn[0] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            cnt_a += int'(press[0]);
            cnt_b += int'(rel[0]);
            if (press[0] && lat < 0) lat = k;
        end
        $display("bounce: presses %0d releases %0d latency %0d", cnt_a, cnt_b, lat);
        chk("bounce_presses", 32'(cnt_a), 32'd1);
        chk("bounce_releases", 32'(cnt_b), 32'd0);
        chk("bounce_lat", 32'(lat >= DB + 1 && lat <= DB + 3), 32'd1);
        btn[0] = 1'b0;
        steps(15);

        // Seven-cycle glitch on channel 2.
        cnt_a = 0;
        btn[2] = 1'b1;
        for (int k = 0; k < 7; k++) begin step(); cnt_a += int'(press[2] | rel[2]); end
        btn[2] = 1'b0;
        for (int k = 0; k < 15; k++) begin step(); cnt_a += int'(press[2] | rel[2]); end
        $display("glitch: pulses %0d level %0b", cnt_a, level[2]);
        chk("glitch_pulses", 32'(cnt_a), 32'd0);
        chk("glitch_level", 32'(level[2]), 32'd0);

        // Press then release on channel 1.
        btn[1] = 1'b1;
        steps(15);
        btn[1] = 1'b0;
        cnt_a = 0; lat = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            cnt_a += int'(rel[1]);
            if (rel[1] && lat < 0) begin
                lat = k;
                chk("release_level", 32'(level[1]), 32'd0);
            end
        end
        $display("release: pulses %0d latency %0d", cnt_a, lat);
        chk("release_pulses", 32'(cnt_a), 32'd1);
        chk("release_lat", 32'(lat >= DB + 1 && lat <= DB + 3), 32'd1);

        // Long hold on channel 4.
        btn[4] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            step();
            if (press[4]) lat = k;
        end
        chk("hold_press_seen", 32'(lat > 0), 32'd1);
        cnt_a = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            cnt_a += int'(press[4] & rpt[4]);
        end
`ifdef ZED_BTN_AUTOREPEAT_EN
        exp_rpts = (100 - RD) / RP + 1;
`else
        exp_rpts = 0;
`endif
        $display("hold: repeat pulses %0d", cnt_a);
        chk("hold_repeats", 32'(cnt_a), 32'(exp_rpts));
        btn[4] = 1'b0;
        steps(15);

        // Reset mid-debounce on channel 3.
        btn[3] = 1'b1;
        steps(5);
        assert_reset();
        steps(1);
        rstn = 1'b1;
        lat = -1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (press[3] && lat < 0) lat = k;
        end
        $display("mid-debounce reset: press latency %0d", lat);
        chk("mid_rst_lat", 32'(lat >= DB + 1 && lat <= DB + 3), 32'd1);
        btn[3] = 1'b0;
        steps(15);

        // Random noise, alternating noisy and calm phases, with rare resets.
        noisy = 1;
        for (int k = 0; k < 4000; k++) begin
            if (k % 500 == 0) noisy = 1 - noisy;
            for (int i = 0; i < NB; i++)
                if ($urandom_range(0, noisy ? 4 : 79) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 999) == 0) begin
                assert_reset();
                steps(2);
                rstn = 1'b1;
            end
            step();
        end
        $display("random phase done at cycle %0d", cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zed_btn_input.md
# zed_btn_input

Input conditioner for the ZedBoard push-buttons. Synchronizes NUM_BTN raw, asynchronous, bouncing button pins into the GCLK domain, debounces each one independently, and emits a clean level plus single-cycle press and release pulses. It sits between the board button pins (BTNC, BTNU, …) and any logic that consumes user input, such as LED pattern controllers.

## Interface
Parameters:
- NUM_BTN, 5, number of button channels.
- DB_CYCLES, 1_000_000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); must be ≥ 2.
- RPT_DELAY_CYCLES, 50_000_000, hold time before the first auto-repeat (only used with auto-repeat).
- RPT_PERIOD_CYCLES, 10_000_000, interval between later auto-repeats (only used with auto-repeat).

Ports (one clock; reset is asynchronous and active-low):
- GCLK  in  1  100 MHz system clock.
- RSTN  in  1  asynchronous active-low reset.
- BTN  in  NUM_BTN  raw button pins, active high, asynchronous to GCLK.
- btn_level  out  NUM_BTN  debounced button state.
- btn_press  out  NUM_BTN  one-cycle pulse per accepted press (and per repeat).
- btn_release  out  NUM_BTN  one-cycle pulse per accepted release.
- btn_repeat  out  NUM_BTN  asserted with btn_press only when that pulse is an auto-repeat.

## Operation
- Each channel is independent and identical. No cross-channel interaction.
- Synchronizer: 2 flops per channel, reset to 0. The second flop output is `s`.
- Debounce counter `cnt`, width $clog2(DB_CYCLES):
  - If `s == btn_level`, then `cnt <= 0`.
  - Otherwise `cnt` increments. When `cnt == DB_CYCLES-1`, `btn_level` toggles and `cnt <= 0`.
- A glitch shorter than DB_CYCLES cycles resets the count and never changes `btn_level`.
- Pulses are registered and asserted in the same cycle that `btn_level` changes:
  - 0→1 gives `btn_press`.
  - 1→0 gives `btn_release`.
  - Press and release can never coincide on one channel.
- Per-channel state: IDLE (level 0), HELD (level 1, repeat timing), REPEAT (level 1, periodic).
  - IDLE→HELD on accepted press.
  - HELD→REPEAT after RPT_DELAY_CYCLES of hold.
  - Any state→IDLE on accepted release.
  - Without auto-repeat, HELD is terminal until release.
- Reset: all flops, counters and outputs go to 0; state goes to IDLE.
  - A button held through reset deassertion is treated as a new press after the normal latency.
  - Reset asserted mid-debounce discards the partial count.

## Timing
- Latency: a clean raw edge that is stable from cycle 0 produces a pulse and level change in cycle DB_CYCLES+2 (2 sync + DB_CYCLES count), ±1 cycle for input sampling.
- Pulse width: exactly 1 GCLK cycle.
- Auto-repeat:
  - First repeat pulse RPT_DELAY_CYCLES cycles after the press pulse.
  - Later repeats every RPT_PERIOD_CYCLES cycles.
- Release during a repeat interval stops all repeats immediately. No repeat pulse may fire in the release cycle.
- Repeat timer width: $clog2(max(RPT_DELAY_CYCLES, RPT_PERIOD_CYCLES)+1). Wrap-around is forbidden; the timer reloads on each repeat.

## Configuration
- ZED_BTN_AUTOREPEAT_EN defined:
  - HELD/REPEAT timing is active.
  - Repeat pulses appear on `btn_press` with `btn_repeat` high.
- Undefined:
  - Repeat timer is not synthesized.
  - `btn_repeat` is tied to 0.
  - `btn_press` fires once per physical press.

## Structure
- Package `zed_io_pkg` holds:
  - `btn_state_e` (IDLE, HELD, REPEAT).
  - Default constants ZED_GCLK_HZ (100_000_000) and ZED_NUM_BTN (5).
- Sub-module `zed_btn_debounce_ch` implements one channel: sync, debounce, state, repeat.
  - The top generates NUM_BTN instances and concatenates the outputs.

## Test plan
Parameters for all tests: DB_CYCLES=8, RPT_DELAY_CYCLES=40, RPT_PERIOD_CYCLES=10.
- Reset: hold RSTN=0 with BTN=5'b11111 → all outputs 0. Release reset → `btn_press`=5'b11111 after 10±1 cycles, for 1 cycle.
- Bounce: BTN[0] toggles every 3 cycles for 30 cycles, then stays 1 → exactly one `btn_press[0]`, 10±1 cycles after the final edge. No release pulse.
- Glitch: BTN[2]=1 for 7 cycles, then 0 → no pulse, and `btn_level[2]` stays 0.
- Release: after press, set BTN[1]=0 → `btn_release[1]` is a single pulse 10±1 cycles later, and `btn_level[1]`=0 the same cycle.
- Auto-repeat (macro on): hold BTN[4] for 100 cycles after the press pulse → repeats at +40, +50, +60, …, +100 with `btn_repeat[4]`=1. Macro off: no repeats, and `btn_repeat` is always 0.
- Mid-debounce reset: BTN[3]=1, pulse RSTN low at cycle 5 → no pulse before cycle 5+10 after reset release.
